// File: rtl/reg_demux_4ch.sv
// Registered 1-to-NCH demultiplexer with one-entry holding register per channel.
// Optional build macro AUTO_SEL_EN: round-robin internal pointer replaces the sel input.
module reg_demux_4ch #(
   parameter int WIDTH = 1,
   parameter int NCH   = 4,
   parameter int SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SEL_W-1:0]     sel,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [SEL_W-1:0]     cur_sel,
   output logic                 err_drop,
   output logic [7:0]           drop_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

   ch_state_t          state_r     [NCH];
   ch_state_t          state_nxt_s [NCH];
   logic [NCH-1:0]     sel_hit_s;
   logic [NCH-1:0]     load_s;
   logic               accept_s;
   logic               drop_s;

`ifdef AUTO_SEL_EN
   logic [SEL_W-1:0]   ptr_r;
   logic               unused_sel_s;

   assign unused_sel_s = ^sel;
   assign cur_sel      = ptr_r;

   // Round-robin pointer advances only when a beat is actually taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= {SEL_W{1'b0}};
      end else if (accept_s) begin
         if (ptr_r == SEL_W'(NCH - 1)) begin
            ptr_r <= {SEL_W{1'b0}};
         end else begin
            ptr_r <= ptr_r + SEL_W'(1);
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end
`else
   assign cur_sel = sel;
`endif

   // Target decode, handshake and load strobes; an out-of-range target hits no channel
   always_comb begin
      sel_hit_s = {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) begin
         sel_hit_s[k] = (cur_sel == SEL_W'(k));
      end
      in_ready = ~|(sel_hit_s & out_valid & ~out_ready);
      accept_s = in_valid & in_ready;
      load_s   = sel_hit_s & {NCH{accept_s}};
      drop_s   = accept_s & ~|sel_hit_s;
   end

   // Per-channel EMPTY/FULL next state; a load wins over a simultaneous drain
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         state_nxt_s[k] = state_r[k];
         case (state_r[k])
            EMPTY: begin
               if (load_s[k]) state_nxt_s[k] = FULL;
               else           state_nxt_s[k] = EMPTY;
            end
            FULL: begin
               if (load_s[k])          state_nxt_s[k] = FULL;
               else if (out_ready[k])  state_nxt_s[k] = EMPTY;
               else                    state_nxt_s[k] = FULL;
            end
            default: state_nxt_s[k] = EMPTY;
         endcase
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) state_r[k] <= EMPTY;
      end else begin
         for (int k = 0; k < NCH; k++) state_r[k] <= state_nxt_s[k];
      end
   end

   // Holding registers keep their data after a drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= {(NCH*WIDTH){1'b0}};
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (load_s[k]) out_data[k*WIDTH +: WIDTH] <= in_data;
            else           out_data[k*WIDTH +: WIDTH] <= out_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Drop pulse and saturating drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_drop <= 1'b0;
         drop_cnt <= 8'h00;
      end else begin
         err_drop <= drop_s;
         if (drop_s && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'h01;
         else                               drop_cnt <= drop_cnt;
      end
   end

   always_comb begin
      for (int k = 0; k < NCH; k++) out_valid[k] = (state_r[k] == FULL);
   end

endmodule

// File: tb/tb_reg_demux_4ch.sv
// Self-checking bench for reg_demux_4ch: directed vector table, corner sequences,
// and randomized traffic against a behavioural channel model.
module tb_reg_demux_4ch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [0:0] a_in_data = 1'b0;
   logic       a_in_valid = 1'b0;
   logic       a_in_ready;
   logic [1:0] a_sel = 2'd0;
   logic [3:0] a_out_data;
   logic [3:0] a_out_valid;
   logic [3:0] a_out_ready = 4'b0000;
   logic [1:0] a_cur_sel;
   logic       a_err_drop;
   logic [7:0] a_drop_cnt;

   logic [0:0] b_in_data = 1'b0;
   logic       b_in_valid = 1'b0;
   logic       b_in_ready;
   logic [1:0] b_sel = 2'd0;
   logic [2:0] b_out_data;
   logic [2:0] b_out_valid;
   logic [2:0] b_out_ready = 3'b000;
   logic [1:0] b_cur_sel;
   logic       b_err_drop;
   logic [7:0] b_drop_cnt;

   int checks = 0;
   int failures = 0;

   logic [3:0] m_valid = 4'b0000;
   logic [3:0] m_data  = 4'b0000;
   int         m_ptr = 0;
   int         m_cnt = 0;
   logic       m_err = 1'b0;

   reg_demux_4ch #(.WIDTH(1), .NCH(4), .SEL_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .cur_sel(a_cur_sel), .err_drop(a_err_drop), .drop_cnt(a_drop_cnt)
   );

   reg_demux_4ch #(.WIDTH(1), .NCH(3), .SEL_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .cur_sel(b_cur_sel), .err_drop(b_err_drop), .drop_cnt(b_drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of dut_a: inputs already driven; model predicts handshake and next state.
   task automatic step();
      int   t;
      logic rdy;
      logic acc;
      @(negedge clk);
`ifdef AUTO_SEL_EN
      t = m_ptr;
`else
      t = int'(a_sel);
`endif
      rdy = (t >= 4) ? 1'b1 : (!m_valid[t] || a_out_ready[t]);
      chk("in_ready", {31'd0, a_in_ready}, {31'd0, rdy});
      chk("cur_sel", {30'd0, a_cur_sel}, t);
      acc = a_in_valid && rdy;
      m_valid = m_valid & ~a_out_ready;
      if (acc && t < 4) begin
         m_valid[t] = 1'b1;
         m_data[t]  = a_in_data[0];
      end
      m_err = acc && (t >= 4);
      if (m_err && m_cnt < 255) m_cnt++;
`ifdef AUTO_SEL_EN
      if (acc) m_ptr = (m_ptr + 1) % 4;
`endif
      @(posedge clk);
      #1;
      chk("out_valid", {28'd0, a_out_valid}, {28'd0, m_valid});
      chk("out_data", {28'd0, a_out_data}, {28'd0, m_data});
      chk("err_drop", {31'd0, a_err_drop}, {31'd0, m_err});
      chk("drop_cnt", {24'd0, a_drop_cnt}, m_cnt);
   endtask

   typedef struct packed {
      logic [1:0] sel;
      logic       vld;
      logic       d;
      logic [3:0] ordy;
      logic       exp_rdy;
      logic [3:0] exp_valid;
      logic [3:0] exp_data;
   } vec_t;

   initial begin
      vec_t vt [10];
      vt[0] = '{2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0001, 4'b0001};
      vt[1] = '{2'd1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0011, 4'b0001};
      vt[2] = '{2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 4'b0001};
      vt[3] = '{2'd2, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0111, 4'b0101};
      vt[4] = '{2'd0, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0111, 4'b0100};
      vt[5] = '{2'd3, 1'b0, 1'b1, 4'b1110, 1'b1, 4'b0001, 4'b0100};
      vt[6] = '{2'd3, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b1001, 4'b1100};
      vt[7] = '{2'd3, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1001, 4'b0100};
      vt[8] = '{2'd1, 1'b1, 1'b1, 4'b1001, 1'b1, 4'b0010, 4'b0110};
      vt[9] = '{2'd1, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0110};

      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {28'd0, a_out_valid}, 32'd0);
      chk("rst_out_data", {28'd0, a_out_data}, 32'd0);
      chk("rst_err_drop", {31'd0, a_err_drop}, 32'd0);
      chk("rst_drop_cnt", {24'd0, a_drop_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifndef AUTO_SEL_EN
      // Directed table, including load+drain on ch0 and ch3
      for (int i = 0; i < 10; i++) begin
         a_sel = vt[i].sel; a_in_valid = vt[i].vld; a_in_data = vt[i].d; a_out_ready = vt[i].ordy;
         #1;
         chk("vec_in_ready", {31'd0, a_in_ready}, {31'd0, vt[i].exp_rdy});
         step();
         chk("vec_out_valid", {28'd0, a_out_valid}, {28'd0, vt[i].exp_valid});
         chk("vec_out_data", {28'd0, a_out_data}, {28'd0, vt[i].exp_data});
      end

      // Back-pressure on ch1, redirect to ch3, then drain ch1 while reloading
      a_sel = 2'd1; a_in_valid = 1'b1; a_in_data = 1'b1; a_out_ready = 4'b0000;
      step();
      a_in_data = 1'b0;
      #1 chk("bp_stall", {31'd0, a_in_ready}, 32'd0);
      step();
      a_sel = 2'd3; a_in_data = 1'b1;
      #1 chk("bp_switch", {31'd0, a_in_ready}, 32'd1);
      step();
      chk("bp_ch3_load", {28'd0, a_out_valid}, 32'hA);
      a_sel = 2'd1; a_in_data = 1'b0; a_out_ready = 4'b0010;
      #1 chk("bp_drain_ready", {31'd0, a_in_ready}, 32'd1);
      step();
      chk("bp_reload", {31'd0, a_out_data[1]}, 32'd0);
      a_in_valid = 1'b0; a_out_ready = 4'b1111;
      step();

      // Routing sweep: bit k of d goes to channel k
      for (int d = 0; d < 16; d++) begin
         for (int k = 0; k < 4; k++) begin
            a_sel = 2'(k); a_in_valid = 1'b1; a_in_data = 1'((d >> k) & 1); a_out_ready = 4'b1111;
            step();
         end
         chk("route_data", {28'd0, a_out_data}, d);
         chk("route_valid", {28'd0, a_out_valid}, 32'h8);
      end
      a_in_valid = 1'b0;
      step();
`else
      // Auto pointer: sel tied to 3 is ignored, pointer cycles 0..3
      a_sel = 2'd3; a_in_valid = 1'b1; a_out_ready = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         a_in_data = 1'($urandom_range(0, 1));
         #1 chk("auto_cur_sel", {30'd0, a_cur_sel}, i % 4);
         step();
      end
      // Stall on ch2 holds the pointer until ch2 drains
      a_out_ready = 4'b1011;
      for (int i = 0; i < 8; i++) step();
      chk("auto_stall_sel", {30'd0, a_cur_sel}, 32'd2);
      chk("auto_stall_rdy", {31'd0, a_in_ready}, 32'd0);
      step();
      chk("auto_stall_hold", {30'd0, a_cur_sel}, 32'd2);
      a_out_ready = 4'b1111;
      step();
      chk("auto_release", {30'd0, a_cur_sel}, 32'd3);
      a_in_valid = 1'b0;
      step();
`endif

      // Reset in mid-transfer with ch2 full: discarded, never delivered
      a_sel = 2'd2; a_in_valid = 1'b1; a_in_data = 1'b1; a_out_ready = 4'b0000;
      repeat (3) step();
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {28'd0, a_out_valid}, 32'd0);
      chk("midrst_drop_cnt", {24'd0, a_drop_cnt}, 32'd0);
      @(posedge clk);
      #1 a_in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_valid = 4'b0000; m_data = 4'b0000; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_cur_sel_ptr", {30'd0, a_cur_sel}, 32'd2 - (`ifdef AUTO_SEL_EN 32'd2 `else 32'd0 `endif));
      a_out_ready = 4'b1111;
      repeat (3) step();
      chk("midrst_no_delivery", {28'd0, a_out_valid}, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         a_sel = 2'($urandom_range(0, 3));
         a_in_valid = ($urandom_range(0, 3) != 0);
         a_in_data = 1'($urandom_range(0, 1));
         a_out_ready = 4'($urandom_range(0, 15));
         step();
      end
      a_in_valid = 1'b0;

`ifndef AUTO_SEL_EN
      // NCH=3 instance: sel=3 is out of range, every beat dropped, counter saturates
      b_sel = 2'd3; b_in_valid = 1'b1; b_in_data = 1'b1; b_out_ready = 3'b000;
      for (int i = 0; i < 300; i++) begin
         #1 chk("drop_in_ready", {31'd0, b_in_ready}, 32'd1);
         @(posedge clk);
         #1;
         chk("drop_pulse", {31'd0, b_err_drop}, 32'd1);
         chk("drop_cnt_sat", {24'd0, b_drop_cnt}, (i + 1 > 255) ? 255 : i + 1);
         chk("drop_ch_valid", {29'd0, b_out_valid}, 32'd0);
      end
      chk("drop_ch_data", {29'd0, b_out_data}, 32'd0);
      b_in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_pulse_end", {31'd0, b_err_drop}, 32'd0);
      chk("drop_cnt_hold", {24'd0, b_drop_cnt}, 32'd255);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
